// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: state codes, opcodes and response bytes.
package uart_cmd_decoder_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned FRAME_ADDR_W = 24;
  localparam int unsigned ADDR_BYTES   = FRAME_ADDR_W / BYTE_W;
  localparam int unsigned DATA_BYTES   = WORD_W / BYTE_W;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_DATA   = 4'd2,
    ST_MEM    = 4'd3,
    ST_TX_HI  = 4'd4,
    ST_TX_LO  = 4'd5,
    ST_TX_RSP = 4'd6
  } state_t;

  localparam logic [BYTE_W-1:0] OPC_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] OPC_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_OK    = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_ERR   = 8'h3F;
  localparam logic [BYTE_W-1:0] RSP_TMO   = 8'h54;

  function automatic logic is_opcode(input logic [BYTE_W-1:0] b);
    return (b == OPC_WRITE) || (b == OPC_READ);
  endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// Collects N bytes MSB-first; done rises the cycle after the Nth byte and holds until clr.
module uart_byte_shifter
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [N*BYTE_W-1:0]   data,
  output logic                  done
);

  localparam int unsigned DATA_W = N * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(N + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt  <= '0;
      data <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      data <= '0;
      done <= 1'b0;
    end else if (shift_en && !done) begin
      data <= {data[DATA_W-BYTE_W-1:0], byte_in};
      cnt  <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(N - 1)) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: 'W' addr[3] data[2] -> write + 'K'; 'R' addr[3] -> read + 2 data bytes.
// Optional inter-byte timeout enabled with CMD_TIMEOUT_EN (responds 'T').
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1330000
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [7:0]        rx_dat,
  input  logic              rx_stb,
  output logic              rx_ack,
  output logic [7:0]        tx_dat,
  output logic              tx_stb,
  input  logic              tx_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_done,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        status
);

  if (ADDR_W > FRAME_ADDR_W || ADDR_W == 0) begin : g_addr_w_range
    $error("ADDR_W must be in 1..24");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t state, state_d;

  logic                      accept_c;
  logic                      tmo_hit_c;
  logic                      addr_shift_c, data_shift_c;
  logic                      addr_done, data_done;
  logic [FRAME_ADDR_W-1:0]   addr_data;
  logic [WORD_W-1:0]         data_data;
  logic                      clr_c;
  logic                      we_d;
  logic [ADDR_W-1:0]         addr_d;
  logic [WORD_W-1:0]         wdata_d;
  logic [BYTE_W-1:0]         tx_dat_d;
  logic [BYTE_W-1:0]         rdata_lo, rdata_lo_d;

  // A byte is consumed once per strobe, and only while collecting a frame.
  assign accept_c = rx_stb && !rx_ack &&
                    ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA));
  assign clr_c    = (state == ST_IDLE);
  assign status   = 4'(state);

  uart_byte_shifter #(.N(ADDR_BYTES)) u_addr_shifter (
    .clk      (clk),
    .nreset   (nreset),
    .clr      (clr_c),
    .shift_en (addr_shift_c),
    .byte_in  (rx_dat),
    .data     (addr_data),
    .done     (addr_done)
  );

  uart_byte_shifter #(.N(DATA_BYTES)) u_data_shifter (
    .clk      (clk),
    .nreset   (nreset),
    .clr      (clr_c),
    .shift_en (data_shift_c),
    .byte_in  (rx_dat),
    .data     (data_data),
    .done     (data_done)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;

  // Inter-byte timer: restarts on each accepted byte, runs only mid-frame.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tmo_cnt <= '0;
    end else if ((state == ST_IDLE) || accept_c) begin
      tmo_cnt <= '0;
    end else if ((state == ST_ADDR) || (state == ST_DATA)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit_c = ((state == ST_ADDR) || (state == ST_DATA)) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    we_d         = mem_we;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    tx_dat_d     = tx_dat;
    rdata_lo_d   = rdata_lo;
    addr_shift_c = 1'b0;
    data_shift_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (is_opcode(rx_dat)) begin
            state_d = ST_ADDR;
            we_d    = (rx_dat == OPC_WRITE);
          end else begin
            state_d  = ST_TX_RSP;
            tx_dat_d = RSP_ERR;
          end
        end
      end
      ST_ADDR: begin
        addr_shift_c = accept_c;
        if (addr_done) begin
          addr_d  = addr_data[ADDR_W-1:0];
          state_d = mem_we ? ST_DATA : ST_MEM;
        end
      end
      ST_DATA: begin
        data_shift_c = accept_c;
        if (data_done) begin
          wdata_d = data_data;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_done) begin
          if (mem_we) begin
            state_d  = ST_TX_RSP;
            tx_dat_d = RSP_OK;
          end else begin
            state_d    = ST_TX_HI;
            tx_dat_d   = mem_rdata[15:8];
            rdata_lo_d = mem_rdata[7:0];
          end
        end
      end
      ST_TX_HI: begin
        if (tx_ack) begin
          state_d  = ST_TX_LO;
          tx_dat_d = rdata_lo;
        end
      end
      ST_TX_LO, ST_TX_RSP: begin
        if (tx_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout abandons the partial frame without touching the memory-side registers.
    if (tmo_hit_c) begin
      state_d      = ST_TX_RSP;
      tx_dat_d     = RSP_TMO;
      addr_d       = mem_addr;
      wdata_d      = mem_wdata;
      addr_shift_c = 1'b0;
      data_shift_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      rx_ack    <= 1'b0;
      tx_dat    <= '0;
      tx_stb    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_lo  <= '0;
    end else begin
      state     <= state_d;
      rx_ack    <= accept_c;
      tx_dat    <= tx_dat_d;
      tx_stb    <= (state_d == ST_TX_HI) || (state_d == ST_TX_LO) || (state_d == ST_TX_RSP);
      mem_req   <= (state_d == ST_MEM);
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      rdata_lo  <= rdata_lo_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder; timeout case runs when CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic        rx_ack;
  logic [7:0]  tx_dat;
  logic        tx_stb;
  logic        tx_ack;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic [3:0]  status;

  int n_chk  = 0;
  int n_fail = 0;
  int req_cnt = 0;
  logic req_q = 1'b0;

  uart_cmd_decoder #(.ADDR_W(24), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .rx_ack    (rx_ack),
    .tx_dat    (tx_dat),
    .tx_stb    (tx_stb),
    .tx_ack    (tx_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .status    (status)
  );

  always #5 clk = ~clk;

  // Count memory requests by rising edge of mem_req.
  always @(posedge clk) begin
    if (mem_req && !req_q) req_cnt <= req_cnt + 1;
    req_q <= mem_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_dat = b;
    rx_stb = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rx_ack) begin
        got = 1'b1;
        break;
      end
    end
    rx_stb = 1'b0;
    check("rx_ack_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
    check("rx_ack_one_cycle", 64'(rx_ack), 64'd0);
  endtask

  task automatic mem_access(input logic exp_we, input logic [23:0] exp_addr,
                            input logic [15:0] exp_wdata, input logic [15:0] rdata,
                            input int delay);
    logic found, stable, acked;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_req) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mem_req_seen", 64'(found), 64'd1);
    check("mem_we", 64'(mem_we), 64'(exp_we));
    check("mem_addr", 64'(mem_addr), 64'(exp_addr));
    if (exp_we) check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    check("status_mem", 64'(status), 64'd3);
    stable = 1'b1;
    acked  = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      if (!mem_req || mem_we !== exp_we || mem_addr !== exp_addr) stable = 1'b0;
      if (rx_ack) acked = 1'b1;
    end
    check("mem_hold_stable", 64'(stable), 64'd1);
    check("rx_ack_low_in_mem", 64'(acked), 64'd0);
    mem_rdata = rdata;
    mem_done  = 1'b1;
    @(posedge clk); #1;
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    check("mem_req_fall", 64'(mem_req), 64'd0);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic [3:0] exp_status, input int hold);
    logic found, stable;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_stb) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("tx_stb_seen", 64'(found), 64'd1);
    check("tx_dat", 64'(tx_dat), 64'(exp));
    check("status_tx", 64'(status), 64'(exp_status));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!tx_stb || tx_dat !== exp || rx_ack) stable = 1'b0;
    end
    check("tx_hold_stable", 64'(stable), 64'd1);
    tx_ack = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {8'h00, rx_ack, tx_stb, mem_req, mem_we, tx_dat, mem_addr, mem_wdata, status}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    nreset    = 1'b0;
    rx_dat    = 8'h00;
    rx_stb    = 1'b0;
    tx_ack    = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    nreset = 1'b1;
    @(posedge clk); #1;
    check("status_idle_after_reset", 64'(status), 64'd0);

    // Write frame 57 01 23 45 BE EF -> 'K'
    r0 = req_cnt;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'hBE); send_byte(8'hEF);
    mem_access(1'b1, 24'h012345, 16'hBEEF, 16'h0000, 3);
    recv_byte(8'h4B, 4'd6, 2);
    check("status_idle_after_write", 64'(status), 64'd0);
    check("write_req_count", 64'(req_cnt - r0), 64'd1);

    // Read frame 52 00 00 10, rdata CAFE -> CA FE
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    mem_access(1'b0, 24'h000010, 16'h0000, 16'hCAFE, 2);
    recv_byte(8'hCA, 4'd4, 3);
    recv_byte(8'hFE, 4'd5, 1);
    check("status_idle_after_read", 64'(status), 64'd0);

    // Bad opcode -> '?', no request, then a read decodes cleanly
    r0 = req_cnt;
    send_byte(8'h41);
    recv_byte(8'h3F, 4'd6, 1);
    check("bad_opcode_no_req", 64'(req_cnt - r0), 64'd0);
    send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    mem_access(1'b0, 24'hABCDEF, 16'h0000, 16'h1357, 0);
    recv_byte(8'h13, 4'd4, 0);
    recv_byte(8'h57, 4'd5, 0);

    // Stray mem_done and tx_ack in IDLE are ignored
    r0 = req_cnt;
    mem_done = 1'b1; tx_ack = 1'b1;
    @(posedge clk); #1;
    mem_done = 1'b0; tx_ack = 1'b0;
    @(posedge clk); #1;
    check("stray_status_idle", 64'(status), 64'd0);
    check("stray_no_tx", 64'(tx_stb), 64'd0);
    check("stray_no_req", 64'(req_cnt - r0), 64'd0);

    // Byte pending during a slow access waits until IDLE
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    rx_dat = 8'h41;
    rx_stb = 1'b1;
    mem_access(1'b0, 24'h000010, 16'h0000, 16'h5AA5, 50);
    recv_byte(8'h5A, 4'd4, 1);
    recv_byte(8'hA5, 4'd5, 1);
    check("pending_not_acked_at_idle_entry", 64'(rx_ack), 64'd0);
    @(posedge clk); #1;
    check("pending_acked_in_idle", 64'(rx_ack), 64'd1);
    rx_stb = 1'b0;
    recv_byte(8'h3F, 4'd6, 0);

    // Reset mid-frame, then a fresh read frame
    send_byte(8'h57); send_byte(8'h01);
    nreset = 1'b0;
    #1;
    check_all_zero("midframe_reset_outputs");
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    mem_access(1'b0, 24'h000001, 16'h0000, 16'h1234, 1);
    recv_byte(8'h12, 4'd4, 0);
    recv_byte(8'h34, 4'd5, 0);
    check("status_idle_after_reset_frame", 64'(status), 64'd0);

`ifdef CMD_TIMEOUT_EN
    // Partial frame then silence -> 'T' 100 cycles after the last byte
    begin
      int n;
      r0 = req_cnt;
      rx_dat = 8'h57; rx_stb = 1'b1;
      for (int i = 0; i < 20 && !rx_ack; i++) begin
        @(posedge clk); #1;
      end
      rx_stb = 1'b0;
      @(posedge clk); #1;
      rx_dat = 8'h01; rx_stb = 1'b1;
      for (int i = 0; i < 20 && !rx_ack; i++) begin
        @(posedge clk); #1;
      end
      rx_stb = 1'b0;
      n = 0;
      while (!tx_stb && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_latency", 64'(n), 64'd100);
      recv_byte(8'h54, 4'd6, 0);
      check("timeout_no_req", 64'(req_cnt - r0), 64'd0);
      check("timeout_back_idle", 64'(status), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
